life_array_grid: RTL and testbench

Parametrised ROWS x COLS Conway's Life cell array; the generalised successor to the fixed 4x4 array.
- Adds selectable toroidal wrap, single-generation stepping, a generation counter, and registered status flags (extinct, still-life, period-2).
- Sits between the host config/write port and the display/readout logic; loaded cell-by-cell, then free-run or stepped.

---
 rtl/life_array_grid.sv | 167 ++++++++++++++++
 tb/tb_life_array_grid.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_array_grid.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | life_array_grid                                                          |
// | ROWS x COLS Conway's Life array: cell-by-cell load, run/step advance,    |
// | optional toroidal wrap, generation counter, extinct/still/osc2 flags.    |
// | Optional serial scan chain when LIFE_SCAN_EN is defined.                 |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module life_array_grid #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int WRAP  = 0,
  parameter int GEN_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(ROWS)-1:0]  row,
  input  logic [$clog2(COLS)-1:0]  col,
  input  logic                     val,
  input  logic                     write_enb,
  input  logic                     run,
  input  logic                     step,
  output logic [ROWS*COLS-1:0]     alive,
  output logic [GEN_W-1:0]         generation,
  output logic                     extinct,
  output logic                     still,
  output logic                     osc2
`ifdef LIFE_SCAN_EN
  ,
  input  logic                     scan_in,
  input  logic                     scan,
  output logic                     scan_out
`endif
);

  localparam int c_cells    = ROWS * COLS;
  localparam bit c_row_pow2 = ((1 << $clog2(ROWS)) == ROWS);
  localparam bit c_col_pow2 = ((1 << $clog2(COLS)) == COLS);

  logic [c_cells-1:0] r_alive;
  logic [c_cells-1:0] r_prev1;
  logic [GEN_W-1:0]   r_gen;
  logic               r_extinct;
  logic               r_still;
  logic               r_osc2;
  logic               r_step_d;

  logic [c_cells-1:0] w_next;
  logic [c_cells-1:0] w_wr_grid;
  logic               w_row_ok;
  logic               w_col_ok;
  logic               w_do_write;
  logic               w_advance;

  assign alive      = r_alive;
  assign generation = r_gen;
  assign extinct    = r_extinct;
  assign still      = r_still;
  assign osc2       = r_osc2;

  // Address range checks only matter when a dimension is not a power of two.
  if (c_row_pow2) begin : g_row_full
    assign w_row_ok = 1'b1;
  end else begin : g_row_chk
    assign w_row_ok = (int'(row) < ROWS);
  end

  if (c_col_pow2) begin : g_col_full
    assign w_col_ok = 1'b1;
  end else begin : g_col_chk
    assign w_col_ok = (int'(col) < COLS);
  end

  assign w_do_write = write_enb && w_row_ok && w_col_ok;
  assign w_advance  = !write_enb && (run || (step && !r_step_d));

  always_comb begin
    w_wr_grid = r_alive;
    for (int i = 0; i < c_cells; i++) begin
      if (i == (int'(col) * ROWS + int'(row))) begin
        w_wr_grid[i] = val;
      end
    end
  end

  // Neighbour wiring is resolved at elaboration; edge cells tie missing
  // neighbours low unless the grid is toroidal.
  for (genvar i = 0; i < c_cells; i++) begin : g_cell
    localparam int c_r = i % ROWS;
    localparam int c_c = i / ROWS;
    logic [7:0] w_nb;
    logic [3:0] w_cnt;

    for (genvar k = 0; k < 8; k++) begin : g_nb
      localparam int c_pos    = (k < 4) ? k : k + 1;
      localparam int c_rr_raw = c_r + (c_pos % 3) - 1;
      localparam int c_cc_raw = c_c + (c_pos / 3) - 1;
      localparam int c_rr     = (c_rr_raw + ROWS) % ROWS;
      localparam int c_cc     = (c_cc_raw + COLS) % COLS;
      localparam bit c_inside = (c_rr_raw >= 0) && (c_rr_raw < ROWS) &&
                                (c_cc_raw >= 0) && (c_cc_raw < COLS);
      if ((WRAP != 0) || c_inside) begin : g_link
        assign w_nb[k] = r_alive[c_cc*ROWS + c_rr];
      end else begin : g_edge
        assign w_nb[k] = 1'b0;
      end
    end

    always_comb begin
      w_cnt = 4'd0;
      for (int k = 0; k < 8; k++) begin
        w_cnt = w_cnt + {3'b000, w_nb[k]};
      end
    end

    assign w_next[i] = (w_cnt == 4'd3) || (r_alive[i] && (w_cnt == 4'd2));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_step_d <= 1'b0;
    end else begin
      r_step_d <= step;
    end
  end

  // Only one generation of history is needed: period-2 means next == gen n-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alive   <= '0;
      r_prev1   <= '0;
      r_gen     <= '0;
      r_extinct <= 1'b1;
      r_still   <= 1'b0;
      r_osc2    <= 1'b0;
    end
`ifdef LIFE_SCAN_EN
    else if (scan) begin
      r_alive   <= {scan_in, r_alive[c_cells-1:1]};
      r_extinct <= ({scan_in, r_alive[c_cells-1:1]} == '0);
      r_still   <= 1'b0;
      r_osc2    <= 1'b0;
    end
`endif
    else if (w_do_write) begin
      r_alive   <= w_wr_grid;
      r_prev1   <= w_wr_grid;
      r_gen     <= '0;
      r_extinct <= (w_wr_grid == '0);
      r_still   <= 1'b0;
      r_osc2    <= 1'b0;
    end else if (w_advance) begin
      r_alive   <= w_next;
      r_prev1   <= r_alive;
      r_gen     <= r_gen + GEN_W'(1);
      r_extinct <= (w_next == '0);
      r_still   <= (w_next == r_alive);
      r_osc2    <= (w_next == r_prev1) && (w_next != r_alive);
    end
  end

`ifdef LIFE_SCAN_EN
  assign scan_out = r_alive[0];
`endif

endmodule
`default_nettype wire

// File: tb/tb_life_array_grid.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_life_array_grid                                                       |
// | Bench for life_array_grid: 4x4 bounded (GEN_W=16) and toroidal (GEN_W=4) |
// | instances against a 2-D array reference model.                           |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_life_array_grid;

  logic        clk;
  logic        reset;
  logic [1:0]  row;
  logic [1:0]  col;
  logic        val;
  logic        write_enb;
  logic        run;
  logic        step;

  logic [15:0] alive0, alive1;
  logic [15:0] gen0;
  logic [3:0]  gen1;
  logic        ext0, ext1, still0, still1, osc0, osc1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: index 0 = bounded grid, index 1 = toroidal grid.
  logic [15:0] m_alive [2];
  logic [15:0] m_prev  [2];
  int          m_gen   [2];
  bit          m_ext   [2];
  bit          m_still [2];
  bit          m_osc   [2];
  bit          m_step_d;
  int          gen_mod [2] = '{65536, 16};

  life_array_grid #(.ROWS(4), .COLS(4), .WRAP(0), .GEN_W(16)) dut0 (
    .clk(clk), .reset(reset), .row(row), .col(col), .val(val),
    .write_enb(write_enb), .run(run), .step(step),
    .alive(alive0), .generation(gen0), .extinct(ext0), .still(still0), .osc2(osc0)
  );

  life_array_grid #(.ROWS(4), .COLS(4), .WRAP(1), .GEN_W(4)) dut1 (
    .clk(clk), .reset(reset), .row(row), .col(col), .val(val),
    .write_enb(write_enb), .run(run), .step(step),
    .alive(alive1), .generation(gen1), .extinct(ext1), .still(still1), .osc2(osc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Life rule on a 4x4 grid held as cell(r,c) = g[c*4+r].
  function automatic logic [15:0] life_next(input logic [15:0] g, input bit wrap);
    logic [15:0] nx;
    int cnt, rr, cc;
    nx = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr == 0 && dc == 0) continue;
            rr = r + dr;
            cc = c + dc;
            if (wrap) begin
              rr = (rr + 4) % 4;
              cc = (cc + 4) % 4;
            end else if (rr < 0 || rr > 3 || cc < 0 || cc > 3) begin
              continue;
            end
            cnt += int'(g[cc*4 + rr]);
          end
        end
        nx[c*4 + r] = (cnt == 3) || (g[c*4 + r] && cnt == 2);
      end
    end
    return nx;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_alive[k] = '0;
      m_prev[k]  = '0;
      m_gen[k]   = 0;
      m_ext[k]   = 1'b1;
      m_still[k] = 1'b0;
      m_osc[k]   = 1'b0;
    end
    m_step_d = 1'b0;
  endtask

  task automatic model_clock();
    bit rose;
    logic [15:0] g, nx;
    if (reset) begin
      model_reset();
      return;
    end
    rose     = step && !m_step_d;
    m_step_d = step;
    for (int k = 0; k < 2; k++) begin
      if (write_enb) begin
        g = m_alive[k];
        g[int'(col)*4 + int'(row)] = val;
        m_alive[k] = g;
        m_prev[k]  = g;
        m_gen[k]   = 0;
        m_ext[k]   = (g == 0);
        m_still[k] = 1'b0;
        m_osc[k]   = 1'b0;
      end else if (run || rose) begin
        nx = life_next(m_alive[k], k == 1);
        m_still[k] = (nx == m_alive[k]);
        m_osc[k]   = (nx == m_prev[k]) && (nx != m_alive[k]);
        m_prev[k]  = m_alive[k];
        m_alive[k] = nx;
        m_gen[k]   = (m_gen[k] + 1) % gen_mod[k];
        m_ext[k]   = (nx == 0);
      end
    end
  endtask

  task automatic compare_all();
    check("alive0", alive0, m_alive[0]);
    check("gen0",   gen0,   m_gen[0]);
    check("ext0",   ext0,   m_ext[0]);
    check("still0", still0, m_still[0]);
    check("osc0",   osc0,   m_osc[0]);
    check("alive1", alive1, m_alive[1]);
    check("gen1",   gen1,   m_gen[1]);
    check("ext1",   ext1,   m_ext[1]);
    check("still1", still1, m_still[1]);
    check("osc1",   osc1,   m_osc[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    compare_all();
  endtask

  task automatic write_cell(input int r, input int c, input bit v);
    row = 2'(r);
    col = 2'(c);
    val = v;
    write_enb = 1'b1;
    tick();
    write_enb = 1'b0;
  endtask

  task automatic load_pattern(input logic [15:0] p);
    for (int i = 0; i < 16; i++) write_cell(i % 4, i / 4, p[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; row = '0; col = '0; val = 1'b0;
    write_enb = 1'b0; run = 1'b0; step = 1'b0;
    model_reset();
    tick();
    tick();
    check("rst_alive", alive0, 32'h0);
    check("rst_ext",   ext0,   32'h1);
    check("rst_gen",   gen0,   32'h0);
    reset = 1'b0;
    tick();

    // Lone cell: holds while idle, dies on one run cycle.
    write_cell(0, 0, 1'b1);
    repeat (5) tick();
    check("single_hold", alive0, 32'h0001);
    check("single_gen0", gen0,   32'h0);
    run = 1'b1;
    tick();
    run = 1'b0;
    check("single_dead", alive0, 32'h0);
    check("single_ext",  ext0,   32'h1);
    check("single_gen1", gen0,   32'h1);

    // Blinker via step pulses; step held high yields one generation only.
    write_cell(1, 0, 1'b1);
    write_cell(1, 1, 1'b1);
    write_cell(1, 2, 1'b1);
    check("blink_load", alive0, 32'h0222);
    step = 1'b1; tick(); step = 1'b0; tick();
    check("blink_g1",  alive0, 32'h0070);
    check("blink_gen", gen0,   32'h1);
    step = 1'b1; tick();
    check("blink_g2",    alive0, 32'h0222);
    check("blink_osc2",  osc0,   32'h1);
    check("blink_still", still0, 32'h0);
    tick(); tick();
    check("step_held", gen0, 32'h2);
    step = 1'b0;
    tick();
    run = 1'b1; step = 1'b1; tick(); step = 1'b0; tick(); tick();
    run = 1'b0; tick();
    check("step_in_run", gen0, 32'h5);

    // Block: still life; the 4-bit counter wraps after 16 generations.
    load_pattern(16'h0660);
    run = 1'b1;
    repeat (10) tick();
    run = 1'b0;
    check("block_alive", alive0, 32'h0660);
    check("block_still", still0, 32'h1);
    check("block_gen",   gen0,   32'd10);
    run = 1'b1;
    repeat (7) tick();
    run = 1'b0;
    check("block_gen17", gen0, 32'd17);
    check("gen4_wrap",   gen1, 32'd1);

    // Beacon: period 2, osc2 from the second generation.
    load_pattern(16'hCC33);
    run = 1'b1;
    tick();
    check("beacon_g1",   alive0, 32'hC813);
    check("beacon_osc1", osc0,   32'h0);
    tick();
    check("beacon_g2",   alive0, 32'hCC33);
    check("beacon_osc2", osc0,   32'h1);
    tick();
    check("beacon_g3",   alive0, 32'hC813);
    run = 1'b0;
    tick();

    // Vertical triple across the top/bottom edge: blinker on the torus only.
    load_pattern(16'h000B);
    step = 1'b1; tick(); step = 1'b0; tick();
    check("edge_bounded", alive0, 32'h0);
    check("edge_torus",   alive1, 32'h1011);

    // Asynchronous reset mid-run.
    load_pattern(16'h0660);
    run = 1'b1;
    tick();
    #2 reset = 1'b1;
    #1;
    check("async_alive0", alive0, 32'h0);
    check("async_alive1", alive1, 32'h0);
    check("async_gen",    gen0,   32'h0);
    check("async_ext",    ext0,   32'h1);
    model_reset();
    tick();
    reset = 1'b0;
    run = 1'b0;
    tick();

    // Random traffic: sporadic writes, run and step, periodic random reloads.
    for (int n = 0; n < 400; n++) begin
      if (n % 60 == 0) begin
        run = 1'b0;
        step = 1'b0;
        load_pattern(16'($urandom));
      end
      write_enb = ($urandom_range(0, 7) == 0);
      row  = 2'($urandom_range(0, 3));
      col  = 2'($urandom_range(0, 3));
      val  = 1'($urandom_range(0, 1));
      run  = ($urandom_range(0, 2) == 0);
      step = 1'($urandom_range(0, 1));
      tick();
    end
    write_enb = 1'b0;
    run = 1'b0;
    step = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
